// File: rtl/counter_src_arbiter.sv
// counter_src_arbiter
//   Shares one pixel-classification Counter among N_SRC pixel streams.
//   One source at a time is granted the Counter for a whole image of
//   IMG_SIZE pixels. Arbitration is round-robin at image granularity. After
//   the last pixel the block waits for the Counter's img_valid, then pulses
//   res_valid with the owning source in res_src.
//
//   Optional feature: define ARB_SRCTAG_EN to overwrite the top
//   $clog2(N_SRC) bits of cnt_pixel_tag with the granted source index.
//
// Ports
//   clk, rst          clock, synchronous active-high reset
//   src_valid/ready   per-source pixel handshake
//   src_data          source i RGB at [i*3*IMG_BIT +: 3*IMG_BIT]
//   src_tag           source i tag at [i*TAG_BIT +: TAG_BIT]
//   cnt_pixel_*       pixel stream toward the Counter
//   cnt_img_valid     Counter result strobe
//   grant_src         currently (or most recently) granted source
//   busy              state != IDLE
//   res_valid/res_src one-cycle result pulse and its source
//   err_spurious      sticky: cnt_img_valid seen outside WAIT_RES
//
// state    | meaning
// IDLE     | no grant; pick the next requester round-robin
// STREAM   | granted source passes pixels straight through to the Counter
// WAIT_RES | image fully sent; waiting for Counter img_valid
module counter_src_arbiter #(
  parameter int N_SRC    = 4,
  parameter int IMG_SIZE = 64,
  parameter int IMG_BIT  = 8,
  parameter int TAG_BIT  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [N_SRC-1:0]             src_valid,
  output logic [N_SRC-1:0]             src_ready,
  input  logic [N_SRC*3*IMG_BIT-1:0]   src_data,
  input  logic [N_SRC*TAG_BIT-1:0]     src_tag,
  output logic                         cnt_pixel_valid,
  input  logic                         cnt_pixel_ready,
  output logic [3*IMG_BIT-1:0]         cnt_pixel_data,
  output logic [TAG_BIT-1:0]           cnt_pixel_tag,
  input  logic                         cnt_img_valid,
  output logic [$clog2(N_SRC)-1:0]     grant_src,
  output logic                         busy,
  output logic                         res_valid,
  output logic [$clog2(N_SRC)-1:0]     res_src,
  output logic                         err_spurious
);

  localparam int SRC_W = $clog2(N_SRC);
  localparam int PIX_W = 3 * IMG_BIT;
  localparam int CNT_W = (IMG_SIZE > 1) ? $clog2(IMG_SIZE) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, WAIT_RES} state_t;

  state_t             state_q, state_d;
  logic [SRC_W-1:0]   grant_q, grant_d;
  logic [SRC_W-1:0]   last_q, last_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               res_valid_q, res_valid_d;
  logic [SRC_W-1:0]   res_src_q, res_src_d;
  logic               err_q, err_d;

  logic               sel_valid;
  logic [PIX_W-1:0]   sel_data;
  logic [TAG_BIT-1:0] sel_tag;
  logic [TAG_BIT-1:0] tag_out;
  logic [SRC_W-1:0]   pick;
  logic [SRC_W-1:0]   idx;

  // Mux of the granted source.
  always_comb begin
    sel_valid = 1'b0;
    sel_data  = '0;
    sel_tag   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (grant_q == SRC_W'(i)) begin
        sel_valid = src_valid[i];
        sel_data  = src_data[i*PIX_W +: PIX_W];
        sel_tag   = src_tag[i*TAG_BIT +: TAG_BIT];
      end
    end
  end

`ifdef ARB_SRCTAG_EN
  always_comb begin
    tag_out = sel_tag;
    tag_out[TAG_BIT-1 -: SRC_W] = grant_q;
  end
`else
  assign tag_out = sel_tag;
`endif

  // Round-robin pick: scan last+1, last+2, ... The scan runs from the
  // farthest offset down so the nearest requester is the final writer.
  always_comb begin
    pick = last_q;
    idx  = '0;
    for (int k = N_SRC; k >= 1; k--) begin
      idx = SRC_W'((int'(last_q) + k) % N_SRC);
      if (src_valid[idx]) pick = idx;
    end
  end

  always_comb begin
    state_d         = state_q;
    grant_d         = grant_q;
    last_d          = last_q;
    count_d         = count_q;
    res_valid_d     = 1'b0;
    res_src_d       = res_src_q;
    err_d           = err_q | (cnt_img_valid && (state_q != WAIT_RES));
    src_ready       = '0;
    cnt_pixel_valid = 1'b0;
    cnt_pixel_data  = '0;
    cnt_pixel_tag   = '0;
    case (state_q)
      IDLE: begin
        if (|src_valid) begin
          grant_d = pick;
          state_d = STREAM;
        end
      end
      STREAM: begin
        cnt_pixel_valid    = sel_valid;
        src_ready[grant_q] = cnt_pixel_ready;
        cnt_pixel_data     = sel_data;
        cnt_pixel_tag      = tag_out;
        if (sel_valid && cnt_pixel_ready) begin
          if (count_q == CNT_W'(IMG_SIZE - 1)) begin
            count_d = '0;
            state_d = WAIT_RES;
          end else begin
            count_d = count_q + 1'b1;
          end
        end
      end
      WAIT_RES: begin
        if (cnt_img_valid) begin
          res_valid_d = 1'b1;
          res_src_d   = grant_q;
          last_d      = grant_q;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      last_q      <= SRC_W'(N_SRC - 1);
      count_q     <= '0;
      res_valid_q <= 1'b0;
      res_src_q   <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      last_q      <= last_d;
      count_q     <= count_d;
      res_valid_q <= res_valid_d;
      res_src_q   <= res_src_d;
      err_q       <= err_d;
    end
  end

  assign grant_src    = grant_q;
  assign busy         = (state_q != IDLE);
  assign res_valid    = res_valid_q;
  assign res_src      = res_src_q;
  assign err_spurious = err_q;

endmodule

// File: tb/tb_counter_src_arbiter.sv
module tb_counter_src_arbiter;
  localparam int N_SRC    = 4;
  localparam int IMG_SIZE = 64;
  localparam int IMG_BIT  = 8;
  localparam int TAG_BIT  = 8;
  localparam int SW       = $clog2(N_SRC);
  localparam int PIX_W    = 3 * IMG_BIT;

  localparam int P_IDLE = 0;
  localparam int P_SEND = 1;
  localparam int P_WAIT = 2;

  logic                       clk;
  logic                       rst;
  logic [N_SRC-1:0]           src_valid;
  logic [N_SRC-1:0]           src_ready;
  logic [N_SRC*PIX_W-1:0]     src_data;
  logic [N_SRC*TAG_BIT-1:0]   src_tag;
  logic                       cnt_pixel_valid;
  logic                       cnt_pixel_ready;
  logic [PIX_W-1:0]           cnt_pixel_data;
  logic [TAG_BIT-1:0]         cnt_pixel_tag;
  logic                       cnt_img_valid;
  logic [SW-1:0]              grant_src;
  logic                       busy;
  logic                       res_valid;
  logic [SW-1:0]              res_src;
  logic                       err_spurious;

  counter_src_arbiter #(
    .N_SRC(N_SRC), .IMG_SIZE(IMG_SIZE), .IMG_BIT(IMG_BIT), .TAG_BIT(TAG_BIT)
  ) dut (
    .clk(clk), .rst(rst),
    .src_valid(src_valid), .src_ready(src_ready),
    .src_data(src_data), .src_tag(src_tag),
    .cnt_pixel_valid(cnt_pixel_valid), .cnt_pixel_ready(cnt_pixel_ready),
    .cnt_pixel_data(cnt_pixel_data), .cnt_pixel_tag(cnt_pixel_tag),
    .cnt_img_valid(cnt_img_valid),
    .grant_src(grant_src), .busy(busy),
    .res_valid(res_valid), .res_src(res_src),
    .err_spurious(err_spurious)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: who owns the Counter, how many pixels of the image
  // have gone out, and the last finished owner.
  int m_phase, m_grant, m_last, m_sent, m_resv, m_ress, m_err;
  int res_delay;
  bit auto_img;
  int n_xfer;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [TAG_BIT-1:0] exp_tag(input int g, input logic [TAG_BIT-1:0] t);
`ifdef ARB_SRCTAG_EN
    return TAG_BIT'((int'(t) % (1 << (TAG_BIT - SW))) + (g << (TAG_BIT - SW)));
`else
    return t;
`endif
  endfunction

  task automatic model_reset();
    m_phase = P_IDLE; m_grant = 0; m_last = N_SRC - 1; m_sent = 0;
    m_resv = 0; m_ress = 0; m_err = 0; res_delay = 0;
  endtask

  task automatic check_outputs();
    logic [N_SRC-1:0]   e_ready;
    logic               e_valid;
    logic [PIX_W-1:0]   e_data;
    logic [TAG_BIT-1:0] e_tag;
    e_ready = '0; e_valid = 1'b0; e_data = '0; e_tag = '0;
    if (m_phase == P_SEND) begin
      e_valid = src_valid[m_grant];
      if (cnt_pixel_ready) e_ready[m_grant] = 1'b1;
      e_data = src_data[m_grant*PIX_W +: PIX_W];
      e_tag  = exp_tag(m_grant, src_tag[m_grant*TAG_BIT +: TAG_BIT]);
    end
    chk("src_ready", src_ready, e_ready);
    chk("pix_valid", cnt_pixel_valid, e_valid);
    chk("pix_data", cnt_pixel_data, e_data);
    chk("pix_tag", cnt_pixel_tag, e_tag);
    chk("grant_src", grant_src, m_grant);
    chk("busy", busy, m_phase != P_IDLE);
    chk("res_valid", res_valid, m_resv);
    chk("res_src", res_src, m_ress);
    chk("err_spurious", err_spurious, m_err);
    if ((src_ready & src_valid) != '0) n_xfer++;
  endtask

  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    if (cnt_img_valid && m_phase != P_WAIT) m_err = 1;
    m_resv = 0;
    case (m_phase)
      P_IDLE: begin
        if (src_valid != '0) begin
          for (int k = 1; k <= N_SRC; k++) begin
            if (src_valid[(m_last + k) % N_SRC]) begin
              m_grant = (m_last + k) % N_SRC;
              break;
            end
          end
          m_phase = P_SEND;
        end
      end
      P_SEND: begin
        if (src_valid[m_grant] && cnt_pixel_ready) begin
          m_sent++;
          if (m_sent == IMG_SIZE) begin
            m_sent = 0;
            m_phase = P_WAIT;
            res_delay = $urandom_range(0, 3);
          end
        end
      end
      default: begin
        if (cnt_img_valid) begin
          m_resv = 1; m_ress = m_grant; m_last = m_grant; m_phase = P_IDLE;
        end
      end
    endcase
  endtask

  // One clock: act as the Counter if enabled, compare at negedge,
  // advance the model, return #1 after the next posedge.
  task automatic tick();
    if (auto_img) begin
      cnt_img_valid = (m_phase == P_WAIT) && (res_delay == 0);
      if (m_phase == P_WAIT && res_delay > 0) res_delay--;
    end
    @(negedge clk);
    check_outputs();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    n_xfer = 0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int gq[$];
    bit seen, other, rdy_wait, prev_busy;
    int n_img;

    rst = 1'b1; src_valid = '0; src_data = '0; src_tag = '0;
    cnt_pixel_ready = 1'b0; cnt_img_valid = 1'b0; auto_img = 1'b1; n_xfer = 0;
    @(posedge clk); #1;
    model_reset();

    chk("rst_grant", grant_src, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", src_ready, 0);
    chk("rst_pix_valid", cnt_pixel_valid, 0);
    chk("rst_res_valid", res_valid, 0);
    chk("rst_err", err_spurious, 0);

    // Single source 2, Counter always ready.
    do_reset();
    src_valid = 4'b0100; cnt_pixel_ready = 1'b1;
    src_data = {$urandom, $urandom, $urandom}; src_tag = $urandom;
    tick();
    chk("t1_grant", grant_src, 2);
    chk("t1_busy", busy, 1);
    seen = 0; rdy_wait = 0;
    for (int i = 0; i < 300 && !seen; i++) begin
      tick();
      if (busy && n_xfer == IMG_SIZE) rdy_wait |= src_ready[2];
      if (res_valid) begin
        seen = 1;
        chk("t1_res_latency", cnt_img_valid, 1);
      end
    end
    chk("t1_res_seen", seen, 1);
    chk("t1_xfers", n_xfer, IMG_SIZE);
    chk("t1_ready_in_wait", rdy_wait, 0);
    chk("t1_res_src", res_src, 2);

    // All four sources requesting: 8 images.
    do_reset();
    src_valid = 4'b1111; prev_busy = 0; other = 0; gq.delete();
    for (int i = 0; i < 1500 && gq.size() < 8; i++) begin
      tick();
      if (busy && !prev_busy) gq.push_back(int'(grant_src));
      if (busy && ((src_ready & ~(4'b0001 << grant_src)) != '0)) other = 1;
      prev_busy = busy;
    end
    for (int k = 0; k < 8; k++)
      chk($sformatf("t2_order%0d", k), (k < gq.size()) ? gq[k] : 99, k % N_SRC);
    chk("t2_other_ready", other, 0);

    // Stall of source 1 mid-image while source 0 requests.
    do_reset();
    src_valid = 4'b0010;
    tick();
    chk("t3_grant", grant_src, 1);
    src_valid = 4'b0011;
    for (int i = 0; i < 200 && n_xfer < 31; i++) tick();
    chk("t3_at31", n_xfer, 31);
    src_valid = 4'b0001;
    repeat (10) tick();
    chk("t3_stall_grant", grant_src, 1);
    chk("t3_stall_busy", busy, 1);
    chk("t3_stall_xfers", n_xfer, 31);
    src_valid = 4'b0011; seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (busy && grant_src != 1) other = 1;
      seen = res_valid;
    end
    chk("t3_res_seen", seen, 1);
    chk("t3_xfers", n_xfer, IMG_SIZE);
    chk("t3_res_src", res_src, 1);
    tick();
    chk("t3_next_grant", grant_src, 0);

    // Spurious img_valid in IDLE.
    do_reset();
    src_valid = '0; auto_img = 0;
    cnt_img_valid = 1'b1;
    tick();
    cnt_img_valid = 1'b0;
    tick();
    chk("t4_err_set", err_spurious, 1);
    chk("t4_idle", busy, 0);
    src_valid = 4'b0001;
    tick();
    chk("t4_fsm_runs", busy, 1);
    chk("t4_err_sticky", err_spurious, 1);
    src_valid = '0;
    do_reset();
    chk("t4_err_clear", err_spurious, 0);
    auto_img = 1;

    // Reset mid-image of source 3; tag handling.
    src_valid = 4'b1000;
    src_tag = $urandom; src_tag[3*TAG_BIT +: TAG_BIT] = 8'h15;
    for (int i = 0; i < 200 && n_xfer < 20; i++) tick();
    chk("t5_at20", n_xfer, 20);
    chk("t5_grant", grant_src, 3);
`ifdef ARB_SRCTAG_EN
    chk("t5_tag", cnt_pixel_tag, 8'hD5);
`else
    chk("t5_tag", cnt_pixel_tag, 8'h15);
`endif
    rst = 1'b1; src_valid = 4'b1001;
    tick();
    rst = 1'b0; n_xfer = 0;
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_ready", src_ready, 0);
    chk("t5_rst_pix_valid", cnt_pixel_valid, 0);
    tick();
    chk("t5_regrant", grant_src, 0);
    chk("t5_regrant_busy", busy, 1);
    seen = 0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      seen = res_valid;
    end
    chk("t5_res_seen", seen, 1);
    chk("t5_full_image", n_xfer, IMG_SIZE);

    // Randomized traffic against the model.
    n_img = 0;
    for (int i = 0; i < 4000; i++) begin
      src_data = {$urandom, $urandom, $urandom};
      src_tag  = $urandom;
      for (int s = 0; s < N_SRC; s++)
        if ($urandom_range(0, 7) == 0) src_valid[s] = ~src_valid[s];
      cnt_pixel_ready = ($urandom_range(0, 3) != 0);
      rst = ($urandom_range(0, 599) == 0);
      tick();
      if (res_valid) n_img++;
    end
    rst = 1'b0;
    chk("rand_progress", n_img > 10, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
